// File: rtl/bus_sel_pkg.sv
// Shared constants, agent code map and FSM state type for the MiniSRC bus select decoder.
package bus_sel_pkg;

    localparam int NUM_SRC = 32'd24;
    localparam int SEL_W   = 32'd5;

    localparam logic [SEL_W-1:0] SEL_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SEL_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SEL_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SEL_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SEL_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SEL_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SEL_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SEL_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SEL_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SEL_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SEL_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SEL_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SEL_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SEL_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SEL_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SEL_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SEL_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SEL_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SEL_ZHIGH  = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZLOW   = 5'd19;
    localparam logic [SEL_W-1:0] SEL_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SEL_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SEL_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SEL_C      = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2
    } bus_dec_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational select-code to one-hot decoder; codes at or above NUM_SRC give an
// all-zero vector and valid = 0.
module onehot_dec import bus_sel_pkg::*; #(
    parameter int NUM_SRC = bus_sel_pkg::NUM_SRC,
    parameter int SEL_W   = bus_sel_pkg::SEL_W
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] vec,
    output logic               valid
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(NUM_SRC);

    // Decode the select code and flag whether it names a real agent
    always_comb begin
        vec   = {NUM_SRC{1'b0}};
        valid = ({1'b0, sel} < LIMIT);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_select_decoder.sv
// Sequenced DRIVE/LOAD register-transfer decoder for the MiniSRC bus.
// Optional invalid-code error pulse enabled by defining BUS_DEC_ERR_EN.
module bus_select_decoder import bus_sel_pkg::*; #(
    parameter int NUM_SRC = bus_sel_pkg::NUM_SRC,
    parameter int SEL_W   = bus_sel_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_src,
    input  logic [SEL_W-1:0]   req_dst,
    input  logic               req_ld,
    output logic [NUM_SRC-1:0] out_en,
    output logic [NUM_SRC-1:0] in_en,
    output logic               busy,
    output logic               done
`ifdef BUS_DEC_ERR_EN
    ,
    output logic               err
`endif
);

    bus_dec_state_t     state_r;
    bus_dec_state_t     state_nxt_s;
    logic               accept_s;

    logic [NUM_SRC-1:0] src_vec_s;
    logic [NUM_SRC-1:0] dst_vec_s;
    logic               src_ok_s;
    logic               dst_ok_s;
    logic [NUM_SRC-1:0] src_oh_s;
    logic [NUM_SRC-1:0] dst_oh_s;

    logic [NUM_SRC-1:0] src_oh_r;
    logic [NUM_SRC-1:0] dst_oh_r;
    logic               ld_r;

    logic [NUM_SRC-1:0] out_en_nxt_s;
    logic [NUM_SRC-1:0] in_en_nxt_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic [NUM_SRC-1:0] out_en_r;
    logic [NUM_SRC-1:0] in_en_r;
    logic               busy_r;
    logic               done_r;

    onehot_dec #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_src_dec (
        .sel   (req_src),
        .vec   (src_vec_s),
        .valid (src_ok_s)
    );

    onehot_dec #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_dst_dec (
        .sel   (req_dst),
        .vec   (dst_vec_s),
        .valid (dst_ok_s)
    );

    // Invalid codes are forced to zero even if the decoder width would alias them
    assign src_oh_s  = src_vec_s & {NUM_SRC{src_ok_s}};
    assign dst_oh_s  = dst_vec_s & {NUM_SRC{dst_ok_s}};

    assign req_ready = (state_r == ST_IDLE) || (state_r == ST_LOAD);
    assign accept_s  = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; LOAD can chain straight into a new DRIVE
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_nxt_s = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Capture the decoded request at the accepting edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            src_oh_r <= {NUM_SRC{1'b0}};
            dst_oh_r <= {NUM_SRC{1'b0}};
            ld_r     <= 1'b0;
        end else if (accept_s) begin
            src_oh_r <= src_oh_s;
            dst_oh_r <= dst_oh_s;
            ld_r     <= req_ld;
        end
    end

    // Output values for the state being entered, so the strobes come straight from flops
    always_comb begin
        out_en_nxt_s = {NUM_SRC{1'b0}};
        in_en_nxt_s  = {NUM_SRC{1'b0}};
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_DRIVE: begin
                out_en_nxt_s = src_oh_s;
                busy_nxt_s   = 1'b1;
            end
            ST_LOAD: begin
                out_en_nxt_s = src_oh_r;
                if (ld_r) begin
                    in_en_nxt_s = dst_oh_r;
                end else begin
                    in_en_nxt_s = {NUM_SRC{1'b0}};
                end
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                out_en_nxt_s = {NUM_SRC{1'b0}};
                in_en_nxt_s  = {NUM_SRC{1'b0}};
                busy_nxt_s   = 1'b0;
                done_nxt_s   = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_en_r <= {NUM_SRC{1'b0}};
            in_en_r  <= {NUM_SRC{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            out_en_r <= out_en_nxt_s;
            in_en_r  <= in_en_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign out_en = out_en_r;
    assign in_en  = in_en_r;
    assign busy   = busy_r;
    assign done   = done_r;

`ifdef BUS_DEC_ERR_EN
    logic src_ok_r;
    logic dst_ok_r;
    logic err_nxt_s;
    logic err_r;

    // Remember code validity alongside the decoded request
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            src_ok_r <= 1'b1;
            dst_ok_r <= 1'b1;
        end else if (accept_s) begin
            src_ok_r <= src_ok_s;
            dst_ok_r <= dst_ok_s;
        end
    end

    // A bad dst only matters when it would actually be loaded
    always_comb begin
        if (state_nxt_s == ST_LOAD) begin
            err_nxt_s = !src_ok_r || (ld_r && !dst_ok_r);
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Error pulse register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_bus_select_decoder.sv
// Bench for bus_select_decoder: cycle-indexed expectation schedule plus directed literal checks.
module tb_bus_select_decoder;

    logic        clk       = 1'b0;
    logic        clr_n     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ld    = 1'b0;
    logic [4:0]  req_src   = 5'd0;
    logic [4:0]  req_dst   = 5'd0;
    logic        req_ready;
    logic [23:0] out_en;
    logic [23:0] in_en;
    logic        busy;
    logic        done;
`ifdef BUS_DEC_ERR_EN
    logic        err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outputs per cycle; a transfer accepted into cycle c owns cycles c (drive) and c+1 (load)
    bit [23:0] m_out  [256];
    bit [23:0] m_in   [256];
    bit        m_busy [256];
    bit        m_done [256];
    bit        m_err  [256];
    bit        m_drv  [256];

    bus_select_decoder dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_ld    (req_ld),
        .out_en    (out_en),
        .in_en     (in_en),
        .busy      (busy),
        .done      (done)
`ifdef BUS_DEC_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit [23:0] agent(input logic [4:0] code);
        if (code < 5'd24) return 24'd1 << code;
        else return 24'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: schedule each accepted transfer's two cycles; reset wipes everything pending
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 256; i++) begin
                m_out[i]  <= 24'd0;
                m_in[i]   <= 24'd0;
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_err[i]  <= 1'b0;
                m_drv[i]  <= 1'b0;
            end
        end else begin
            if (req_valid && !m_drv[cyc % 256]) begin
                m_out[(cyc + 1) % 256]  <= agent(req_src);
                m_in[(cyc + 1) % 256]   <= 24'd0;
                m_busy[(cyc + 1) % 256] <= 1'b1;
                m_drv[(cyc + 1) % 256]  <= 1'b1;
                m_out[(cyc + 2) % 256]  <= agent(req_src);
                m_in[(cyc + 2) % 256]   <= req_ld ? agent(req_dst) : 24'd0;
                m_busy[(cyc + 2) % 256] <= 1'b1;
                m_done[(cyc + 2) % 256] <= 1'b1;
                m_err[(cyc + 2) % 256]  <= (req_src >= 5'd24) || (req_ld && (req_dst >= 5'd24));
            end
            m_out[(cyc + 3) % 256]  <= 24'd0;
            m_in[(cyc + 3) % 256]   <= 24'd0;
            m_busy[(cyc + 3) % 256] <= 1'b0;
            m_done[(cyc + 3) % 256] <= 1'b0;
            m_err[(cyc + 3) % 256]  <= 1'b0;
            m_drv[(cyc + 3) % 256]  <= 1'b0;
            cyc <= cyc + 1;
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        chk("out_en",    32'(out_en),    32'(m_out[cyc % 256]));
        chk("in_en",     32'(in_en),     32'(m_in[cyc % 256]));
        chk("busy",      32'(busy),      32'(m_busy[cyc % 256]));
        chk("done",      32'(done),      32'(m_done[cyc % 256]));
        chk("req_ready", 32'(req_ready), 32'(!m_drv[cyc % 256]));
`ifdef BUS_DEC_ERR_EN
        chk("err",       32'(err),       32'(m_err[cyc % 256]));
`endif
    end

    task automatic put(input logic [4:0] s, input logic [4:0] d, input logic l);
        req_src   = s;
        req_dst   = d;
        req_ld    = l;
        req_valid = 1'b1;
    endtask

    task automatic nxt;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 clr_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out",   32'(out_en),    32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        clr_n = 1'b1;

        // PC -> MDR with load
        nxt; put(5'd20, 5'd21, 1'b1);
        nxt; req_valid = 1'b0;
        chk("t1_n1_out", 32'(out_en), 32'h0010_0000);
        chk("t1_n1_in",  32'(in_en),  32'h0);
        nxt;
        chk("t1_n2_out",  32'(out_en), 32'h0010_0000);
        chk("t1_n2_in",   32'(in_en),  32'h0020_0000);
        chk("t1_n2_done", 32'(done),   32'h1);
        nxt;
        chk("t1_n3_out",   32'(out_en),    32'h0);
        chk("t1_n3_done",  32'(done),      32'h0);
        chk("t1_n3_ready", 32'(req_ready), 32'h1);

        // Back-to-back 3->5 then 19->0 with valid held
        put(5'd3, 5'd5, 1'b1);
        nxt; put(5'd19, 5'd0, 1'b1);
        chk("b2b_n1_out", 32'(out_en), 32'h0000_0008);
        nxt;
        chk("b2b_n2_out",  32'(out_en), 32'h0000_0008);
        chk("b2b_n2_in",   32'(in_en),  32'h0000_0020);
        chk("b2b_n2_done", 32'(done),   32'h1);
        nxt; req_valid = 1'b0;
        chk("b2b_n3_out",  32'(out_en), 32'h0008_0000);
        chk("b2b_n3_busy", 32'(busy),   32'h1);
        chk("b2b_n3_done", 32'(done),   32'h0);
        nxt;
        chk("b2b_n4_out",  32'(out_en), 32'h0008_0000);
        chk("b2b_n4_in",   32'(in_en),  32'h0000_0001);
        chk("b2b_n4_done", 32'(done),   32'h1);
        nxt;
        chk("b2b_n5_busy", 32'(busy), 32'h0);

        // Drive-only HI -> R7
        put(5'd16, 5'd7, 1'b0);
        nxt; req_valid = 1'b0;
        chk("ld0_n1_in", 32'(in_en), 32'h0);
        nxt;
        chk("ld0_n2_out",  32'(out_en), 32'h0001_0000);
        chk("ld0_n2_in",   32'(in_en),  32'h0);
        chk("ld0_n2_done", 32'(done),   32'h1);

        // Invalid src and dst
        nxt; put(5'd27, 5'd30, 1'b1);
        nxt; req_valid = 1'b0;
        chk("inv_n1_out",  32'(out_en), 32'h0);
        chk("inv_n1_busy", 32'(busy),   32'h1);
        nxt;
        chk("inv_n2_out",  32'(out_en), 32'h0);
        chk("inv_n2_in",   32'(in_en),  32'h0);
        chk("inv_n2_done", 32'(done),   32'h1);
`ifdef BUS_DEC_ERR_EN
        chk("inv_n2_err",  32'(err),    32'h1);
`endif

        // src == dst
        nxt; put(5'd7, 5'd7, 1'b1);
        nxt; req_valid = 1'b0;
        nxt;
        chk("same_n2_out", 32'(out_en), 32'h0000_0080);
        chk("same_n2_in",  32'(in_en),  32'h0000_0080);

        // Invalid dst with ld=0 is not an error
        nxt; put(5'd5, 5'd25, 1'b0);
        nxt; req_valid = 1'b0;
        nxt;
        chk("dst0_n2_out",  32'(out_en), 32'h0000_0020);
        chk("dst0_n2_done", 32'(done),   32'h1);
`ifdef BUS_DEC_ERR_EN
        chk("dst0_n2_err",  32'(err),    32'h0);
`endif

        // Reset in the DRIVE cycle of 4 -> 9
        nxt; put(5'd4, 5'd9, 1'b1);
        nxt; req_valid = 1'b0;
        chk("rmid_n1_out", 32'(out_en), 32'h0000_0010);
        #2 clr_n = 1'b0;
        #1;
        chk("rmid_out",   32'(out_en),    32'h0);
        chk("rmid_busy",  32'(busy),      32'h0);
        chk("rmid_ready", 32'(req_ready), 32'h1);
        nxt;
        chk("rmid_done", 32'(done), 32'h0);
        clr_n = 1'b1;
        nxt;
        chk("rpost_done",  32'(done),      32'h0);
        chk("rpost_ready", 32'(req_ready), 32'h1);

        // Normal transfer after reset: R2 -> R12
        put(5'd2, 5'd12, 1'b1);
        nxt; req_valid = 1'b0;
        nxt;
        chk("post_n2_out",  32'(out_en), 32'h0000_0004);
        chk("post_n2_in",   32'(in_en),  32'h0000_1000);
        chk("post_n2_done", 32'(done),   32'h1);
        repeat (2) nxt;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
